// File: rtl/isp_uart_pkg.sv
// Shared types and constants for the fabric-side MMUART receiver.
// State enum, oversampling constants and data width.
package isp_uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

endpackage

// File: rtl/isp_uart_rx_fifo.sv
// First-word-fall-through byte FIFO with valid/ready pop side.
// Drops a push that finds the FIFO full with no pop, flagging overflow.
module isp_uart_rx_fifo
  import isp_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              ready,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              pop;
  logic              wr_en;

  assign valid = wr_ptr != rd_ptr;
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
              && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = valid && ready;
  // a pop in the same cycle frees the slot the push needs
  assign wr_en    = push && (!full || pop);
  assign overflow = push && full && !pop;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/isp_uart_rx.sv
// 16x oversampling UART receiver (8N1, or 8E1 with ISP_UART_RX_PARITY_EN)
// feeding a FWFT FIFO; sticky frame/overrun/parity flags.
module isp_uart_rx
  import isp_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK_BASE,
  input  logic              RESET_N,
  input  logic              RXD,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  input  logic              RX_READY,
  output logic              FRAME_ERR,
  output logic              OVERRUN,
`ifdef ISP_UART_RX_PARITY_EN
  output logic              PARITY_ERR,
`endif
  input  logic              ERR_CLR
);

`ifdef ISP_UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = S_PARITY;
`else
  localparam rx_state_t AFTER_DATA = S_STOP;
`endif

  rx_state_t         state;
  logic              sync1;
  logic              rxs;
  logic [11:0]       tick_cnt;
  logic              tick;
  logic [3:0]        samp;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              bit_done;
  logic              push;
  logic              fe_set;
  logic              ovf;

  assign tick     = tick_cnt == 12'(BAUD_DIV - 1);
  assign bit_done = tick && (samp == 4'(OVERSAMPLE - 1));
  assign fe_set   = (state == S_STOP) && bit_done && !rxs;

`ifdef ISP_UART_RX_PARITY_EN
  logic par_bad;
  logic par_set;
  assign par_set = (state == S_PARITY) && bit_done
                && (^{shreg, rxs});
  assign push    = (state == S_STOP) && bit_done
                && rxs && !par_bad;
`else
  assign push    = (state == S_STOP) && bit_done && rxs;
`endif

  always_ff @(posedge CLK_BASE or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= RXD;
      rxs   <= sync1;
    end
  end

  // restart the bit timebase at the falling edge of the start bit
  always_ff @(posedge CLK_BASE or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt <= '0;
    end else if ((state == S_IDLE && !rxs) || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 12'd1;
    end
  end

  always_ff @(posedge CLK_BASE or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      samp    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef ISP_UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            samp  <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (samp == 4'(MID_SAMPLE - 1)) begin
              state   <= rxs ? S_IDLE : S_DATA;
              samp    <= '0;
              bit_cnt <= '0;
            end else begin
              samp <= samp + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            samp <= samp + 4'd1;
            if (bit_done) begin
              shreg   <= {rxs, shreg[DATA_W-1:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= AFTER_DATA;
              end
            end
          end
        end
`ifdef ISP_UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            samp <= samp + 4'd1;
            if (bit_done) begin
              par_bad <= ^{shreg, rxs};
              state   <= S_STOP;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            samp <= samp + 4'd1;
            if (bit_done) begin
              state <= rxs ? S_IDLE : S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rxs) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_BASE or negedge RESET_N) begin
    if (!RESET_N) begin
      FRAME_ERR  <= 1'b0;
      OVERRUN    <= 1'b0;
`ifdef ISP_UART_RX_PARITY_EN
      PARITY_ERR <= 1'b0;
`endif
    end else begin
      FRAME_ERR  <= fe_set | (FRAME_ERR & ~ERR_CLR);
      OVERRUN    <= ovf | (OVERRUN & ~ERR_CLR);
`ifdef ISP_UART_RX_PARITY_EN
      PARITY_ERR <= par_set | (PARITY_ERR & ~ERR_CLR);
`endif
    end
  end

  isp_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK_BASE),
    .rst_n     (RESET_N),
    .push      (push),
    .push_data (shreg),
    .ready     (RX_READY),
    .head      (RX_DATA),
    .valid     (RX_VALID),
    .overflow  (ovf)
  );

endmodule
